// File: rtl/pc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_pkg : shared types and default widths for the PC/branch unit       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package pc_pkg;

    typedef enum logic [1:0] {
        JM_SEQ     = 2'b00,
        JM_LUT_REL = 2'b01,
        JM_LUT_ABS = 2'b10,
        JM_IMM_REL = 2'b11
    } jump_mode_t;

    localparam int D_DEF         = 12;
    localparam int LUT_DEPTH_DEF = 16;
    localparam int RAS_DEPTH_DEF = 4;
    localparam int IMM_W_DEF     = 4;

endpackage
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_ras : circular return-address stack with sticky over/underflow     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pc_ras
    import pc_pkg::*;
#(
    parameter int D         = D_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic         underflow
);

    localparam int PW   = $clog2(RAS_DEPTH);
    localparam int CNTW = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0]   c_ptr_one = PW'(1);
    localparam logic [CNTW-1:0] c_cnt_one = CNTW'(1);
    localparam logic [CNTW-1:0] c_depth   = CNTW'(RAS_DEPTH);

    logic [D-1:0]    r_mem [RAS_DEPTH];
    logic [PW-1:0]   r_top;            // next slot to write; wraps so a full push overwrites the oldest
    logic [CNTW-1:0] r_count;
    logic            r_overflow;
    logic            r_underflow;
    logic [PW-1:0]   w_last;

    assign w_last    = r_top - c_ptr_one;
    assign pop_data  = r_mem[w_last];
    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (pop) begin
            if (empty) begin
                r_underflow <= 1'b1;
            end else begin
                r_top   <= w_last;
                r_count <= r_count - c_cnt_one;
            end
        end else if (push) begin
            r_top <= r_top + c_ptr_one;
            if (full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push && !pop) begin
            r_mem[r_top] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_branch_unit : PC register, writable branch-target LUT and RAS      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pc_branch_unit
    import pc_pkg::*;
#(
    parameter int D         = D_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF,
    parameter int IMM_W     = IMM_W_DEF,
    localparam int LW       = $clog2(LUT_DEPTH),
    localparam int CW       = (LW > IMM_W) ? LW : IMM_W
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall,
    input  logic          halt,
    input  logic [1:0]    jump_mode,
    input  logic          branch_en,
    input  logic          call,
    input  logic          ret,
    input  logic [CW-1:0] pc_ctrl_input,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  pc,
    output logic          halted,
    output logic          ras_overflow,
    output logic          ras_underflow
);

    localparam logic [D-1:0] c_pc_one = D'(1);

    logic [D-1:0]  r_pc;
    logic          r_halted;
    logic [D-1:0]  r_lut [LUT_DEPTH];

    jump_mode_t    w_mode;
    logic [LW-1:0] w_idx;
    logic [D-1:0]  w_imm_ext;
    logic [D-1:0]  w_pc_inc;
    logic [D-1:0]  w_target;
    logic [D-1:0]  w_pc_next;
    logic          w_taken;
    logic          w_active;
    logic          w_push;
    logic          w_pop;
    logic [D-1:0]  w_ras_data;
    logic          w_ras_empty;
    logic          w_ras_full_unused;

    assign w_mode    = jump_mode_t'(jump_mode);
    assign w_idx     = pc_ctrl_input[LW-1:0];
    assign w_imm_ext = {{(D-IMM_W){pc_ctrl_input[IMM_W-1]}}, pc_ctrl_input[IMM_W-1:0]};
    assign w_pc_inc  = r_pc + c_pc_one;
    assign w_taken   = (w_mode != JM_SEQ) && (branch_en || call);
    assign w_active  = !halt && !r_halted && !stall;
    // ret outranks call, so a simultaneous call never pushes
    assign w_pop     = w_active && ret;
    assign w_push    = w_active && call && !ret;

    always_comb begin
        w_target = w_pc_inc;
        case (w_mode)
            JM_LUT_REL: w_target = r_pc + r_lut[w_idx];
            JM_LUT_ABS: w_target = r_lut[w_idx];
            JM_IMM_REL: w_target = r_pc + w_imm_ext;
            default:    w_target = w_pc_inc;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        if (w_active) begin
            if (ret) begin
                w_pc_next = w_ras_empty ? w_pc_inc : w_ras_data;
            end else if (w_taken) begin
                w_pc_next = w_target;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                r_lut[i] <= '0;
            end
        end else begin
            r_pc <= w_pc_next;
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (lut_we) begin
                r_lut[lut_waddr] <= lut_wdata;
            end
        end
    end

    pc_ras #(
        .D         (D),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .pop_data  (w_ras_data),
        .full      (w_ras_full_unused),
        .empty     (w_ras_empty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    assign pc     = r_pc;
    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pc_branch_unit : directed plus random bench with reference model   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_pc_branch_unit;

    localparam int PC_MOD = 4096;
    localparam int RAS_D  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  jump_mode = 2'b00;
    logic        branch_en = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [3:0]  pc_ctrl_input = 4'd0;
    logic        lut_we = 1'b0;
    logic [3:0]  lut_waddr = 4'd0;
    logic [11:0] lut_wdata = 12'd0;
    logic [11:0] pc;
    logic        halted;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    int m_pc = 0;
    bit m_halted = 1'b0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int m_lut [16];
    int m_ras [$];

    pc_branch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .halt          (halt),
        .jump_mode     (jump_mode),
        .branch_en     (branch_en),
        .call          (call),
        .ret           (ret),
        .pc_ctrl_input (pc_ctrl_input),
        .lut_we        (lut_we),
        .lut_waddr     (lut_waddr),
        .lut_wdata     (lut_wdata),
        .pc            (pc),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at one rising edge, from the architectural rules
    task automatic model_step();
        int idx, imm, tgt;
        bit taken;
        if (!reset_n) begin
            m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
            m_ras.delete();
            return;
        end
        idx = int'(pc_ctrl_input);
        imm = int'(pc_ctrl_input);
        if (imm >= 8) imm -= 16;
        case (jump_mode)
            2'b01:   tgt = (m_pc + m_lut[idx]) % PC_MOD;
            2'b10:   tgt = m_lut[idx];
            2'b11:   tgt = (m_pc + imm + PC_MOD) % PC_MOD;
            default: tgt = (m_pc + 1) % PC_MOD;
        endcase
        taken = (jump_mode != 2'b00) && (branch_en || call);
        if (halt || m_halted) begin
            m_halted = 1;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (m_ras.size() == 0) begin
                m_unf = 1;
                m_pc = (m_pc + 1) % PC_MOD;
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else begin
            if (call) begin
                m_ras.push_back((m_pc + 1) % PC_MOD);
                if (m_ras.size() > RAS_D) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
            end
            m_pc = taken ? tgt : (m_pc + 1) % PC_MOD;
        end
        if (lut_we) m_lut[int'(lut_waddr)] = int'(lut_wdata);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ":pc"},        {20'd0, pc},    m_pc);
        check({tag, ":halted"},    {31'd0, halted}, {31'd0, m_halted});
        check({tag, ":overflow"},  {31'd0, ras_overflow}, {31'd0, m_ovf});
        check({tag, ":underflow"}, {31'd0, ras_underflow}, {31'd0, m_unf});
    endtask

    task automatic idle();
        reset_n = 1; stall = 0; halt = 0; jump_mode = 2'b00; branch_en = 0;
        call = 0; ret = 0; pc_ctrl_input = 4'd0; lut_we = 0; lut_waddr = 4'd0; lut_wdata = 12'd0;
    endtask

    task automatic stall_write(input logic [3:0] a, input logic [11:0] d);
        idle(); stall = 1; lut_we = 1; lut_waddr = a; lut_wdata = d;
        cycle("stall_write");
    endtask

    task automatic go_abs(input logic [3:0] a);
        idle(); jump_mode = 2'b10; pc_ctrl_input = a; branch_en = 1;
        cycle("go_abs");
    endtask

    initial begin
        foreach (m_lut[i]) m_lut[i] = 0;
        idle(); reset_n = 0;
        cycle("reset0"); cycle("reset1");
        check("reset_pc", {20'd0, pc}, 32'd0);

        idle();
        for (int i = 0; i < 5; i++) cycle("seq");
        check("seq_pc5", {20'd0, pc}, 32'd5);

        stall_write(4'd15, 12'd4095);
        go_abs(4'd15);
        check("pc_max", {20'd0, pc}, 32'd4095);
        idle(); cycle("wrap");
        check("wrap_zero", {20'd0, pc}, 32'd0);

        stall_write(4'd4, 12'd10);
        go_abs(4'd4);
        stall_write(4'd3, 12'hFFB);
        check("stall_write_hold", {20'd0, pc}, 32'd10);
        idle(); jump_mode = 2'b01; pc_ctrl_input = 4'd3; branch_en = 1; cycle("lut_rel");
        check("lut_rel_neg", {20'd0, pc}, 32'd5);

        stall_write(4'd3, 12'h020);
        go_abs(4'd3);
        check("lut_abs", {20'd0, pc}, 32'h020);
        idle(); jump_mode = 2'b10; pc_ctrl_input = 4'd3; branch_en = 1;
        lut_we = 1; lut_waddr = 4'd3; lut_wdata = 12'd7;
        cycle("lut_same_cycle");
        check("lut_old_value", {20'd0, pc}, 32'h020);
        go_abs(4'd3);
        check("lut_new_value", {20'd0, pc}, 32'd7);

        idle(); cycle("to8");
        idle(); jump_mode = 2'b11; pc_ctrl_input = 4'hE; cycle("imm_not_taken");
        check("imm_not_taken", {20'd0, pc}, 32'd9);
        idle(); jump_mode = 2'b11; pc_ctrl_input = 4'hF; branch_en = 1; cycle("imm_m1");
        idle(); jump_mode = 2'b11; pc_ctrl_input = 4'hE; branch_en = 1; cycle("imm_m2");
        check("imm_taken", {20'd0, pc}, 32'd6);

        stall_write(4'd5, 12'd20);
        stall_write(4'd1, 12'd100);
        stall_write(4'd2, 12'd200);
        go_abs(4'd5);
        idle(); call = 1; jump_mode = 2'b10; pc_ctrl_input = 4'd1; cycle("call1");
        idle(); call = 1; jump_mode = 2'b10; pc_ctrl_input = 4'd2; cycle("call2");
        check("call_nest", {20'd0, pc}, 32'd200);
        idle(); ret = 1; cycle("ret1");
        check("ret_inner", {20'd0, pc}, 32'd101);
        idle(); ret = 1; cycle("ret2");
        check("ret_outer", {20'd0, pc}, 32'd21);

        idle(); call = 1;
        for (int i = 0; i < 5; i++) cycle("call_ovf");
        check("ovf_flag", {31'd0, ras_overflow}, 32'd1);
        idle(); ret = 1;
        for (int i = 0; i < 5; i++) cycle("ret_unf");
        check("unf_pc", {20'd0, pc}, 32'd24);
        check("unf_flag", {31'd0, ras_underflow}, 32'd1);
        idle(); cycle("sticky0"); cycle("sticky1");

        idle(); reset_n = 0; call = 1; jump_mode = 2'b10; branch_en = 1; lut_we = 1; lut_waddr = 4'd3;
        cycle("reset_mid");
        check("reset_mid_pc", {20'd0, pc}, 32'd0);
        go_abs(4'd3);
        check("lut_cleared", {20'd0, pc}, 32'd0);

        idle(); stall = 1; call = 1;
        for (int i = 0; i < 3; i++) cycle("stall");
        check("stall_hold", {20'd0, pc}, 32'd0);
        idle(); ret = 1; cycle("ret_after_stall");
        check("no_push_in_stall", {20'd0, pc}, 32'd1);

        idle(); call = 1; cycle("push_one");
        idle(); call = 1; ret = 1; jump_mode = 2'b10; pc_ctrl_input = 4'd3; branch_en = 1;
        cycle("call_ret");
        idle(); ret = 1; cycle("ret_empty");

        idle(); halt = 1; jump_mode = 2'b11; pc_ctrl_input = 4'd5; branch_en = 1;
        cycle("halt");
        idle(); jump_mode = 2'b11; pc_ctrl_input = 4'd5; branch_en = 1;
        for (int i = 0; i < 3; i++) cycle("halted_frozen");
        check("halted_flag", {31'd0, halted}, 32'd1);
        idle(); reset_n = 0; cycle("halt_reset");

        for (int i = 0; i < 800; i++) begin
            reset_n       = ($urandom_range(0, 59) != 0);
            stall         = ($urandom_range(0, 7) == 0);
            halt          = ($urandom_range(0, 199) == 0);
            jump_mode     = 2'($urandom);
            branch_en     = 1'($urandom);
            call          = ($urandom_range(0, 3) == 0);
            ret           = ($urandom_range(0, 3) == 0);
            pc_ctrl_input = 4'($urandom);
            lut_we        = ($urandom_range(0, 2) == 0);
            lut_waddr     = 4'($urandom);
            lut_wdata     = 12'($urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program-counter unit for the team's custom processor. It owns the PC register, a run-time-writable branch-target LUT, and a small return-address stack (RAS), and supports relative, absolute and immediate branches plus call/return. It sits between the decoder (branch controls, 4-bit LUT index/immediate) and instruction memory (PC output). It replaces the fixed combinational target LUT.

## Interface
Parameters:
- D, 12: PC and target width.
- LUT_DEPTH, 16: branch-target LUT entries. Index width LW = $clog2(LUT_DEPTH).
- RAS_DEPTH, 4: return-address stack entries (power of 2, ≥2).
- IMM_W, 4: immediate width, sign-extended to D.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- stall  in  1  hold the PC; suppress push/pop.
- halt  in  1  freeze the PC permanently until reset.
- jump_mode  in  2  00 seq, 01 LUT-relative, 10 LUT-absolute, 11 immediate-relative.
- branch_en  in  1  branch condition true; ignored when jump_mode=00.
- call  in  1  push PC+1 and take the branch selected by jump_mode.
- ret  in  1  pop the RAS into the PC.
- pc_ctrl_input  in  max(LW,IMM_W)  LUT index (low LW bits) or immediate (low IMM_W bits).
- lut_we  in  1  LUT write enable.
- lut_waddr  in  LW  LUT write index.
- lut_wdata  in  D  LUT write data, two's complement when used as an offset.
- pc  out  D  current program counter.
- halted  out  1  sticky halt indicator.
- ras_overflow  out  1  sticky: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky: a pop occurred while the RAS was empty.

## Operation
- Reset (reset_n=0 at an edge): pc=0, all LUT entries=0, RAS empty, halted=0, ras_overflow=0, ras_underflow=0. Reset overrides every other input, including mid-call or mid-write.
- Branch target:
  - 01: pc + LUT[idx]
  - 10: LUT[idx]
  - 11: pc + sext(imm)
  - All arithmetic is modulo 2^D; wrap-around is silent.
- Taken = (jump_mode≠00) && (branch_en || call).
- Next-PC priority, highest first:
  - halt or halted: hold pc, set halted.
  - stall: hold pc.
  - ret: pop value.
  - taken: target.
  - otherwise: pc+1. pc+1 at 2^D−1 wraps to 0.
- call with jump_mode=00: push pc+1; next pc = pc+1.
- call and ret in the same cycle: ret wins and the pop happens; the call is ignored with no push.
- RAS behaviour:
  - Circular buffer. Push when full overwrites the oldest entry, sets ras_overflow, and count stays RAS_DEPTH.
  - Pop when empty: next pc = pc+1, sets ras_underflow, and count stays 0.
- LUT writes:
  - Performed whenever lut_we=1, even during stall or halt.
  - A same-cycle read of the same index returns the old value; the new value is visible from the next cycle.
- Sticky flags clear only on reset.

## Timing
- Single-cycle: controls sampled at edge k determine pc after edge k. pc is a registered output with no combinational input-to-output path.
- RAS push/pop and LUT write commit at the same edge as the PC update.
- stall holds the PC for exactly the cycles it is asserted. There is no internal queuing of branch, call or ret requests during stall.
- halted rises at the edge that samples halt=1.

## Structure
- Package pc_pkg:
  - jump_mode_t enum: JM_SEQ, JM_LUT_REL, JM_LUT_ABS, JM_IMM_REL.
  - Default widths D_DEF=12, LUT_DEPTH_DEF=16.
- Sub-module pc_ras: parametrised by D and RAS_DEPTH. Ports: push, pop, push_data, pop_data, full, empty, overflow, underflow, plus clk and reset_n.
- The LUT is an in-module register array; it requires no separate module.

## Test plan
- Sequential from reset: reset_n=0 for 2 cycles, then 5 cycles of jump_mode=00 → pc = 0,1,2,3,4,5. At pc=4095 (D=12), the next pc is 0.
- LUT program and branch: write LUT[3]=−5 (0xFFB) at pc=10, then jump_mode=01, idx=3, branch_en=1 → next pc=5. Repeat with mode 10 and LUT[3]=0x020 → pc=0x020. A same-cycle write of LUT[3]=7 uses the old value.
- Immediate branch: pc=8, mode=11, imm=4'b1110 → pc=6. With branch_en=0 → pc=9.
- Call/return nesting: at pc=20, call mode=10 with LUT[1]=100 → pc=100. At pc=100, call mode=10 with LUT[2]=200 → pc=200. Then ret → 101, ret → 21. No flags are set.
- RAS boundaries (RAS_DEPTH=4): 5 calls → ras_overflow=1 and the first return address is lost. 5 rets → the 5th yields pc_prev+1 and ras_underflow=1. Both flags clear only on reset.
- Stall/halt/reset: stall for 3 cycles → pc constant, with a call held during stall producing no push. halt → halted=1 and pc frozen despite branches. reset_n=0 mid-sequence → pc=0 and flags 0 at the next edge.
